pe_broadcast_recv_fsm: RTL and testbench
========================================

// Module: pe_broadcast_recv_fsm
// PURPOSE
//  Receive end of the PE activation-broadcast protocol. Accepts packets from the
//  router ejection port, decodes activation packets into (global index, value)
//  and queues them for the local MAC array. Counts per-PE end-of-broadcast
//  packets and pulses layer_done once every PE has finished and the queue drains.
// PARAMETERS
//  DATA_W      16  activation / packet data width (matches PeDataBus)
//  ADDR_W      16  router address width; MSB = finish flag
//  PE_IDX_W    6   PE index field, addr[PE_IDX_W-1:0]
//  ACT_IDX_W   6   local activation position field, above PE_IDX
//  NUM_PE      64  finish packets expected per layer (1..2**PE_IDX_W)
//  FIFO_DEPTH  4   activation queue depth, power of 2, >=2
// PORTS
//  clk         in   1                    system clock
//  rst         in   1                    async reset, active high
//  layer_start in   1                    begin a layer (pulse)
//  in_valid    in   1                    router packet valid
//  in_data     in   DATA_W               packet data
//  in_addr     in   ADDR_W               packet address
//  in_rdy      out  1                    receiver can accept packet
//  out_valid   out  1                    activation available to MAC
//  out_data    out  DATA_W               activation value
//  out_idx     out  ACT_IDX_W+PE_IDX_W   global index {position, src PE}
//  out_rdy     in   1                    MAC consumes activation
//  layer_done  out  1                    one-cycle pulse, layer fully received
//  err_dup_fin out  1                    sticky duplicate-finish flag
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, fin_cnt=0; in_rdy, out_valid, layer_done,
//   err_dup_fin = 0; out_data/out_idx = 0.
//  Transfer on in_valid&in_rdy; pop on out_valid&out_rdy. in_rdy combinational:
//   state==RECV && !fifo_full (no dependence on in_valid).
//  Packet decode: in_addr[ADDR_W-1]=0 -> activation: push {in_addr[ACT_IDX_W+
//   PE_IDX_W-1:0], in_data}; bits between index and MSB ignored.
//   in_addr[ADDR_W-1]=1 -> finish: not pushed; src PE = in_data[PE_IDX_W-1:0].
//  States:
//   IDLE : in_rdy=0; layer_start -> RECV, fin_cnt<=0, err_dup_fin<=0.
//   RECV : accept packets; finish accepted with fin_cnt==NUM_PE-1 -> DRAIN,
//          otherwise fin_cnt++. layer_start ignored.
//   DRAIN: in_rdy=0; FIFO keeps popping; fifo empty -> layer_done=1 for exactly
//          that cycle, -> IDLE.
//  Latency: accepted activation visible at out_* next cycle (registered FIFO);
//   layer_done earliest one cycle after last finish if FIFO empty.
//  FIFO: out_* from head entry, stable while out_valid&&!out_rdy. Push+pop same
//   cycle legal at any occupancy <full; full blocks push via in_rdy; pointers
//   wrap modulo FIFO_DEPTH, extra bit distinguishes full/empty.
//  Finish and activation ordering: finish never bypasses queued data, since
//   layer_done waits for empty FIFO.
//  Reset mid-layer: FIFO flushed, count cleared, no layer_done.
// CONFIGURATION
//  RECV_FINISH_CHECK_EN defined: NUM_PE-bit bitmap of finished PEs, cleared on
//   layer_start; repeat finish from same PE sets err_dup_fin (sticky to next
//   layer_start) and does not advance fin_cnt. Finish with src PE >= NUM_PE also
//   sets err_dup_fin, no count.
//  Undefined: no bitmap; every finish advances fin_cnt; err_dup_fin tied 0.
// STRUCTURE
//  Shared header (pe.vh / router.vh): finish-flag bit position, PE_IDX/ACT_IDX
//   field widths and offsets, PE count, data width — same defines the sender uses.
//  Sub-module pe_act_recv_fifo: sync FIFO, width DATA_W+ACT_IDX_W+PE_IDX_W, depth
//   FIFO_DEPTH, push/pop/full/empty. FSM and decode stay in this module.
// TESTING
//  NUM_PE=2; start; act addr=0x0045 data=0x1234, out_rdy=1 -> next cycle
//   out_valid, out_idx=0x045, out_data=0x1234.
//  out_rdy=0, push 5 acts (DEPTH=4) -> in_rdy low after 4th, 5th held, out_*
//   stable; release out_rdy -> all 5 out in order.
//  Finish data=0,1 (addr=0x8000) with FIFO empty -> layer_done single pulse
//   cycle after 2nd finish, in_rdy=0, state IDLE.
//  Finish #2 while 3 acts queued, out_rdy=1 -> layer_done only after 3rd pop.
//  _EN on: finish PE 0 twice then PE 1 -> err_dup_fin=1, no done until PE 1;
//   off: second PE0 finish completes layer.
//  Assert rst mid-RECV with 2 queued -> out_valid=0, in_rdy=0, no layer_done;
//   new layer_start runs a clean layer.

Source files
------------

// File: rtl/pe_broadcast_recv_fsm_pkg.sv
// Shared definitions for the activation-broadcast receiver: field widths, finish-flag
// position and FSM state encoding, kept identical to the sending side.
package pe_broadcast_recv_fsm_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int PE_IDX_W_DEF   = 6;
  localparam int ACT_IDX_W_DEF  = 6;
  localparam int NUM_PE_DEF     = 64;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } recv_state_t;

  // Address bit that marks a packet as end-of-broadcast rather than activation data.
  function automatic int fin_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/pe_broadcast_recv_fsm_if.sv
// Router-ejection and MAC-side handshake bundle for the broadcast receiver.
// slave = receiver view, master = router/MAC view.
interface pe_broadcast_recv_fsm_if
  import pe_broadcast_recv_fsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = ACT_IDX_W_DEF + PE_IDX_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_rdy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_rdy;

  modport master (
    output in_valid, in_data, in_addr, out_rdy,
    input  in_rdy, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, in_addr, out_rdy,
    output in_rdy, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/pe_act_recv_fifo.sv
// Synchronous FIFO holding decoded activations; head entry drives the outputs directly.
// Latency: pushed entry visible next cycle. Backpressure: full blocks push, push+pop legal below full.
module pe_act_recv_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pe_broadcast_recv_fsm.sv
// Broadcast receiver: queues activations for the MAC, counts finish packets, pulses layer_done.
// Latency: activation on out_* one cycle after accept. Backpressure: in_rdy drops when queue full
// or not receiving. Optional duplicate-finish bitmap under RECV_FINISH_CHECK_EN.
module pe_broadcast_recv_fsm
  import pe_broadcast_recv_fsm_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PE_IDX_W   = PE_IDX_W_DEF,
  parameter int ACT_IDX_W  = ACT_IDX_W_DEF,
  parameter int NUM_PE     = NUM_PE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    layer_start,
  pe_broadcast_recv_fsm_if.slave  bus,
  output logic                    layer_done,
  output logic                    err_dup_fin
);
  localparam int IDX_W = ACT_IDX_W + PE_IDX_W;
  localparam int FW    = DATA_W + IDX_W;
  localparam int CNT_W = PE_IDX_W + 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  recv_state_t   state;
  logic [CNT_W-1:0] fin_cnt;
  logic          is_fin;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          empty_next;
  logic          fin_counts;
  logic [FW-1:0] head;
  logic [LW-1:0] fifo_count;
  logic          unused_addr_bits;

  assign is_fin      = bus.in_addr[fin_bit(ADDR_W)];
  assign bus.in_rdy  = (state == ST_RECV) && !fifo_full;
  assign accept      = bus.in_valid && bus.in_rdy;
  assign push        = accept && !is_fin;
  assign pop         = bus.out_valid && bus.out_rdy;
  assign empty_next  = fifo_empty || ((fifo_count == LW'(1)) && pop);
  assign bus.out_valid = !fifo_empty;
  assign {bus.out_idx, bus.out_data} = head;
  assign unused_addr_bits = ^bus.in_addr[ADDR_W-2:IDX_W];

  pe_act_recv_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({bus.in_addr[IDX_W-1:0], bus.in_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head),
    .count    (fifo_count)
  );

`ifdef RECV_FINISH_CHECK_EN
  logic [PE_IDX_W-1:0] fin_src;
  logic [NUM_PE-1:0]   fin_map;
  logic [NUM_PE-1:0]   src_oh;
  logic                err_q;

  assign fin_src = bus.in_data[PE_IDX_W-1:0];
  always_comb begin
    src_oh = '0;
    for (int i = 0; i < NUM_PE; i++) src_oh[i] = (fin_src == PE_IDX_W'(i));
  end
  // Out-of-range sources give an all-zero one-hot and are rejected like duplicates.
  assign fin_counts  = (|src_oh) && !(|(fin_map & src_oh));
  assign err_dup_fin = err_q;
`else
  assign fin_counts  = 1'b1;
  assign err_dup_fin = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fin_cnt    <= '0;
      layer_done <= 1'b0;
`ifdef RECV_FINISH_CHECK_EN
      fin_map    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      layer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (layer_start) begin
            state   <= ST_RECV;
            fin_cnt <= '0;
`ifdef RECV_FINISH_CHECK_EN
            fin_map <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        ST_RECV: begin
          if (accept && is_fin) begin
            if (fin_counts) begin
`ifdef RECV_FINISH_CHECK_EN
              fin_map <= fin_map | src_oh;
`endif
              if (fin_cnt == CNT_W'(NUM_PE - 1)) begin
                state      <= ST_DRAIN;
                layer_done <= empty_next;
              end else begin
                fin_cnt <= fin_cnt + 1'b1;
              end
            end
`ifdef RECV_FINISH_CHECK_EN
            else begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        ST_DRAIN: begin
          // layer_done is high during the one DRAIN cycle that sees an empty queue.
          if (fifo_empty) state <= ST_IDLE;
          else            layer_done <= empty_next;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_broadcast_recv_fsm.sv
// Bench for pe_broadcast_recv_fsm with NUM_PE=2: vector table plus hand sequences,
// scoreboard queue checked on every MAC-side pop.
module tb_pe_broadcast_recv_fsm;
  logic clk = 1'b0;
  logic rst;
  logic layer_start;
  logic layer_done;
  logic err_dup_fin;

  pe_broadcast_recv_fsm_if bus ();

  pe_broadcast_recv_fsm #(.NUM_PE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .layer_start (layer_start),
    .bus         (bus),
    .layer_done  (layer_done),
    .err_dup_fin (err_dup_fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [11:0] exp_idx;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs [4];
  logic [27:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          d0;
  int          cyc;
  logic        prev_done = 1'b0;
  logic [27:0] exp_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] addr, input logic [15:0] data,
                      input logic [11:0] exp_idx, input logic [15:0] exp_data);
    bit ok;
    ok = 1'b0;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (!addr[15]) sb.push_back({exp_idx, exp_data});
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_rdy stayed 0 for addr %0h, required 1 within 60 cycles", addr);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic fin(input logic [15:0] src);
    send(16'h8000, src, 12'h000, 16'h0000);
  endtask

  task automatic start_layer();
    step();
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
  endtask

  task automatic wait_drained(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  // Scoreboard: every MAC-side pop must match the oldest expected activation.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_done = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_rdy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got idx %0h data %0h, required no output", bus.out_idx, bus.out_data);
        end else begin
          exp_e = sb.pop_front();
          chk("sb_pop", {bus.out_idx, bus.out_data}, exp_e);
        end
      end
      if (layer_done) begin
        done_cnt++;
        chk("done_single_pulse", prev_done, 0);
      end
      prev_done = layer_done;
    end
  end

  initial begin
    vecs[0] = '{16'h0045, 16'h1234, 12'h045, 16'h1234};
    vecs[1] = '{16'h7FC5, 16'hBEEF, 12'hFC5, 16'hBEEF};
    vecs[2] = '{16'h0FFF, 16'h0000, 12'hFFF, 16'h0000};
    vecs[3] = '{16'h1000, 16'hA5A5, 12'h000, 16'hA5A5};

    rst = 1'b1;
    layer_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_addr  = '0;
    bus.out_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_err", err_dup_fin, 0);
    chk("rst_out_bus", {bus.out_idx, bus.out_data}, 0);
    step();
    rst = 1'b0;

    // Vector table: decode and next-cycle visibility.
    start_layer();
    @(negedge clk);
    chk("start_in_rdy", bus.in_rdy, 1);
    step();
    bus.out_rdy = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].addr, vecs[i].data, vecs[i].exp_idx, vecs[i].exp_data);
      @(negedge clk);
      chk("vec_out_valid", bus.out_valid, 1);
      chk("vec_out_idx", bus.out_idx, vecs[i].exp_idx);
      chk("vec_out_data", bus.out_data, vecs[i].exp_data);
      step();
    end
    wait_drained("vec_drained");

    // Backpressure: four fill the queue, fifth is held until the MAC pops.
    step();
    bus.out_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(16'h0100 + 16'(i), 16'hC000 + 16'(i), 12'h100 + 12'(i), 16'hC000 + 16'(i));
      end
      begin
        repeat (6) @(negedge clk);
        chk("full_in_rdy", bus.in_rdy, 0);
        chk("full_sb_size", sb.size(), 4);
        chk("full_head_idx", bus.out_idx, 12'h100);
        chk("full_head_data", bus.out_data, 16'hC000);
        step();
        bus.out_rdy = 1'b1;
      end
    join
    wait_drained("bp_drained");

    // Two finishes with empty queue: done one cycle after the second.
    step();
    d0 = done_cnt;
    fin(16'd0);
    @(negedge clk);
    chk("fin1_no_done", layer_done, 0);
    chk("fin1_in_rdy", bus.in_rdy, 1);
    step();
    fin(16'd1);
    @(negedge clk);
    chk("fin2_done", layer_done, 1);
    chk("fin2_in_rdy", bus.in_rdy, 0);
    @(negedge clk);
    chk("fin2_done_low", layer_done, 0);
    chk("fin2_idle", bus.in_rdy, 0);
    chk("fin2_done_cnt", done_cnt - d0, 1);

    // Final finish with three queued: done only after the third pop.
    start_layer();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'h0200 + 16'(i), 16'h7700 + 16'(i), 12'h200 + 12'(i), 16'h7700 + 16'(i));
    fin(16'd0);
    fin(16'd1);
    @(negedge clk);
    chk("drain_no_done", layer_done, 0);
    chk("drain_in_rdy", bus.in_rdy, 0);
    step();
    bus.out_rdy = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (layer_done) begin
        cyc = n;
        break;
      end
    end
    chk("drain_done_cycle", cyc, 4);
    chk("drain_sb_empty", sb.size(), 0);
    @(negedge clk);

    // Duplicate finish from PE 0.
    start_layer();
    fin(16'd0);
    @(negedge clk);
    chk("dup_first_err", err_dup_fin, 0);
    step();
    fin(16'd0);
    @(negedge clk);
`ifdef RECV_FINISH_CHECK_EN
    chk("dup_no_done", layer_done, 0);
    chk("dup_err", err_dup_fin, 1);
    chk("dup_in_rdy", bus.in_rdy, 1);
    step();
    fin(16'd1);
    @(negedge clk);
    chk("dup_pe1_done", layer_done, 1);
    chk("dup_err_sticky", err_dup_fin, 1);
    @(negedge clk);
    start_layer();
    @(negedge clk);
    chk("range_err_clear", err_dup_fin, 0);
    step();
    fin(16'd5);
    @(negedge clk);
    chk("range_err", err_dup_fin, 1);
    chk("range_no_done", layer_done, 0);
    step();
    fin(16'd0);
    fin(16'd1);
    @(negedge clk);
    chk("range_done", layer_done, 1);
`else
    chk("dup_done", layer_done, 1);
    chk("dup_err_tied", err_dup_fin, 0);
    chk("dup_in_rdy", bus.in_rdy, 0);
`endif
    @(negedge clk);

    // Reset in the middle of a layer with two entries queued.
    start_layer();
    bus.out_rdy = 1'b0;
    send(16'h0301, 16'h1111, 12'h301, 16'h1111);
    send(16'h0302, 16'h2222, 12'h302, 16'h2222);
    @(negedge clk);
    chk("mid_out_valid", bus.out_valid, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_rdy", bus.in_rdy, 0);
    chk("mid_rst_done", layer_done, 0);
    d0 = done_cnt;
    step();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", bus.in_rdy, 0);
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_empty", bus.out_valid, 0);
    bus.out_rdy = 1'b1;
    start_layer();
    send(16'h0123, 16'h5555, 12'h123, 16'h5555);
    @(negedge clk);
    chk("clean_out_idx", bus.out_idx, 12'h123);
    chk("clean_out_data", bus.out_data, 16'h5555);
    step();
    fin(16'd0);
    fin(16'd1);
    @(negedge clk);
    chk("clean_done", layer_done, 1);
    @(negedge clk);
    chk("clean_done_cnt", done_cnt - d0, 1);

    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
